// File: rtl/oled_rect_draw.sv
// Rectangle drawing engine for the 128x64 OLED display RAM: turns one clear,
// filled-box or hollow-box command into a stream of page-major byte writes.
module oled_rect_draw #(
  parameter int COLS  = 128,
  parameter int PAGES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       color,
  input  logic [6:0] x0,
  input  logic [6:0] x1,
  input  logic [5:0] y0,
  input  logic [5:0] y1,
  output logic       busy,
  output logic       done,
  output logic       wren,
  output logic [9:0] wraddress,
  output logic [7:0] data
);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, FIN} state_t;

  state_t     state, state_n;
  logic [1:0] mode_q;
  logic       color_q;
  logic [6:0] x0_q, x1_q, x_cnt, x_n;
  logic [5:0] y0_q, y1_q;
  logic [2:0] pg_cnt, pg_n;
  logic       more, more_n, load;
  logic       busy_n, done_n, wren_n;
  logic [9:0] wraddress_n;
  logic [7:0] data_n;

  logic       clear_m, hollow_m, last;
  logic [6:0] xlo, xhi, cur_x;
  logic [5:0] ylo, yhi;
  logic [2:0] p_lo, p_hi, cur_pg, lo_sh, hi_sh;
  logic [7:0] fill_mask, edge_mask, mask;
  logic [9:0] cur_addr;

  // Corners are normalised from the latched command; mode 3 falls through to filled.
  always_comb begin
    clear_m  = (mode_q == 2'd0);
    hollow_m = (mode_q == 2'd2);
    if (clear_m) begin
      xlo = 7'd0;
      xhi = 7'(COLS - 1);
      ylo = 6'd0;
      yhi = 6'(PAGES * 8 - 1);
    end else begin
      xlo = (x0_q > x1_q) ? x1_q : x0_q;
      xhi = (x0_q > x1_q) ? x0_q : x1_q;
      ylo = (y0_q > y1_q) ? y1_q : y0_q;
      yhi = (y0_q > y1_q) ? y0_q : y1_q;
    end
    p_lo = ylo[5:3];
    p_hi = yhi[5:3];
  end

  // SETUP already emits the first byte so the first write lands two cycles after start.
  always_comb begin
    cur_x    = (state == SETUP) ? xlo  : x_cnt;
    cur_pg   = (state == SETUP) ? p_lo : pg_cnt;
    last     = (cur_x == xhi) && (cur_pg == p_hi);
    cur_addr = 10'(cur_pg * COLS) + 10'(cur_x);
    lo_sh    = (cur_pg == p_lo) ? ylo[2:0] : 3'd0;
    hi_sh    = (cur_pg == p_hi) ? yhi[2:0] : 3'd7;
    fill_mask = (8'hFF << lo_sh) & (8'hFF >> (3'd7 - hi_sh));
    edge_mask = ((cur_pg == p_lo) ? (8'd1 << ylo[2:0]) : 8'd0)
              | ((cur_pg == p_hi) ? (8'd1 << yhi[2:0]) : 8'd0);
    if (clear_m)
      mask = 8'hFF;
    else if (hollow_m && (cur_x != xlo) && (cur_x != xhi))
      mask = edge_mask;
    else
      mask = fill_mask;
  end

  always_comb begin
    state_n     = state;
    x_n         = x_cnt;
    pg_n        = pg_cnt;
    more_n      = more;
    load        = 1'b0;
    busy_n      = busy;
    done_n      = 1'b0;
    wren_n      = 1'b0;
    wraddress_n = wraddress;
    data_n      = data;
    case (state)
      IDLE: begin
        if (start && en) begin
          load    = 1'b1;
          busy_n  = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP, WRITE: begin
        if (state == SETUP || more) begin
          wren_n      = 1'b1;
          wraddress_n = cur_addr;
          data_n      = color_q ? mask : ~mask;
          more_n      = !last;
          state_n     = WRITE;
          // Counters hold on the final byte instead of wrapping.
          if (!last) begin
            if (cur_x == xhi) begin
              x_n  = xlo;
              pg_n = cur_pg + 3'd1;
            end else begin
              x_n  = cur_x + 7'd1;
              pg_n = cur_pg;
            end
          end
        end else begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = FIN;
        end
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state != IDLE && !en) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      wren_n  = 1'b0;
      done_n  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      wren      <= 1'b0;
      wraddress <= 10'd0;
      data      <= 8'd0;
      x_cnt     <= 7'd0;
      pg_cnt    <= 3'd0;
      more      <= 1'b0;
      mode_q    <= 2'd0;
      color_q   <= 1'b0;
      x0_q      <= 7'd0;
      x1_q      <= 7'd0;
      y0_q      <= 6'd0;
      y1_q      <= 6'd0;
    end else begin
      state     <= state_n;
      busy      <= busy_n;
      done      <= done_n;
      wren      <= wren_n;
      wraddress <= wraddress_n;
      data      <= data_n;
      x_cnt     <= x_n;
      pg_cnt    <= pg_n;
      more      <= more_n;
      if (load) begin
        mode_q  <= mode;
        color_q <= color;
        x0_q    <= x0;
        x1_q    <= x1;
        y0_q    <= y0;
        y1_q    <= y1;
      end
    end
  end

endmodule

// File: tb/tb_oled_rect_draw.sv
// Scoreboard bench for oled_rect_draw: a per-pixel reference model queues the
// expected RAM writes, and a negedge monitor pops and compares them.
module tb_oled_rect_draw;

  logic       clk = 1'b0;
  logic       rst, en, start, color;
  logic [1:0] mode;
  logic [6:0] x0, x1;
  logic [5:0] y0, y1;
  logic       busy, done, wren;
  logic [9:0] wraddress;
  logic [7:0] data;

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fails  = 0;
  int  cyc = 0;
  int  wr_count = 0;
  int  done_count = 0;
  int  last_wr_cyc = -10;
  int  first_wren_cyc = 0;
  int  start_cyc = 0;
  bit  first_pending = 0;

  oled_rect_draw #(.COLS(128), .PAGES(8)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .color(color),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .busy(busy), .done(done),
    .wren(wren), .wraddress(wraddress), .data(data)
  );

  always #500 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Reference model: decide every pixel independently, then pack bytes.
  task automatic push_expected(input int m, input int c, input int ax0, input int ax1,
                               input int ay0, input int ay1);
    int xl, xh, yl, yh, row;
    logic [7:0] b;
    wr_t e;
    if (m == 0) begin
      xl = 0; xh = 127; yl = 0; yh = 63;
    end else begin
      xl = (ax0 < ax1) ? ax0 : ax1;  xh = (ax0 < ax1) ? ax1 : ax0;
      yl = (ay0 < ay1) ? ay0 : ay1;  yh = (ay0 < ay1) ? ay1 : ay0;
    end
    for (int p = yl / 8; p <= yh / 8; p++) begin
      for (int x = xl; x <= xh; x++) begin
        b = 8'h00;
        for (int bt = 0; bt < 8; bt++) begin
          row = p * 8 + bt;
          if (row >= yl && row <= yh &&
              (m != 2 || x == xl || x == xh || row == yl || row == yh))
            b[bt] = 1'b1;
        end
        e.a = 10'(p * 128 + x);
        e.d = (c != 0) ? b : ~b;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input int m, input int c, input int ax0, input int ax1,
                               input int ay0, input int ay1);
    @(posedge clk); #1;
    push_expected(m, c, ax0, ax1, ay0, ay1);
    mode = 2'(m); color = c[0];
    x0 = 7'(ax0); x1 = 7'(ax1); y0 = 6'(ay0); y1 = 6'(ay1);
    start = 1'b1;
    first_pending = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("busy_after_start", busy, 1);
  endtask

  task automatic waitDone(input int max_cycles);
    int d0;
    d0 = done_count;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk); #1;
      if (done_count != d0) break;
    end
    checkOutput("done_seen", done_count - d0, 1);
    checkOutput("queue_drained", exp_q.size(), 0);
    checkOutput("first_wren_latency", first_wren_cyc - start_cyc, 2);
    exp_q.delete();
  endtask

  task automatic waitWrites(input int target, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (wr_count >= target) break;
      @(negedge clk); #1;
    end
    checkOutput("write_progress", wr_count, target);
  endtask

  always @(negedge clk) begin
    if (wren) begin
      wr_count++;
      last_wr_cyc = cyc;
      if (first_pending) begin
        first_wren_cyc = cyc;
        first_pending = 1'b0;
      end
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", 1, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        checkOutput("wraddress", wraddress, e.a);
        checkOutput("data", data, e.d);
      end
    end
    if (done) begin
      done_count++;
      checkOutput("done_wren_low", wren, 0);
      checkOutput("done_busy_low", busy, 0);
      checkOutput("done_after_last", cyc - last_wr_cyc, 1);
    end
  end

  initial begin
    #60_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0, d0;
    rst = 1'b1; en = 1'b1; start = 1'b0; mode = 2'd0; color = 1'b0;
    x0 = 7'd0; x1 = 7'd0; y0 = 6'd0; y1 = 6'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_wren", wren, 0);
    checkOutput("reset_wraddress", wraddress, 0);
    checkOutput("reset_data", data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] clear screen");
    applyStimulus(0, 1, 5, 9, 1, 2);
    waitDone(1100);

    $display("[TB] filled, swapped/inverted, hollow and degenerate boxes");
    applyStimulus(1, 1, 10, 12, 3, 10);   waitDone(50);
    applyStimulus(1, 0, 12, 10, 10, 3);   waitDone(50);
    applyStimulus(2, 1, 0, 3, 0, 7);      waitDone(50);
    applyStimulus(2, 1, 5, 9, 5, 20);     waitDone(50);
    applyStimulus(3, 1, 127, 120, 63, 57); waitDone(50);
    applyStimulus(1, 1, 40, 40, 17, 17);  waitDone(50);
    applyStimulus(2, 0, 77, 77, 2, 30);   waitDone(50);
    applyStimulus(2, 1, 100, 105, 33, 33); waitDone(50);

    $display("[TB] abort with ignored restart");
    w0 = wr_count;
    applyStimulus(0, 1, 0, 0, 0, 0);
    waitWrites(w0 + 5, 20);
    start = 1'b1; mode = 2'd1; x0 = 7'd50; x1 = 7'd60;
    @(negedge clk); #1;
    start = 1'b0;
    waitWrites(w0 + 100, 200);
    en = 1'b0;
    @(negedge clk); #1;
    checkOutput("abort_wren", wren, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_write_count", wr_count - w0, 100);
    checkOutput("abort_remaining", exp_q.size(), 924);
    exp_q.delete();
    first_pending = 1'b0;
    d0 = done_count;
    repeat (5) @(negedge clk);
    checkOutput("abort_no_done", done_count - d0, 0);
    en = 1'b1;
    applyStimulus(0, 1, 0, 0, 0, 0);
    waitDone(1100);

    $display("[TB] reset mid-operation");
    w0 = wr_count;
    applyStimulus(1, 1, 10, 12, 3, 10);
    waitWrites(w0 + 2, 10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_wren", wren, 0);
    checkOutput("midreset_wraddress", wraddress, 0);
    checkOutput("midreset_data", data, 0);
    checkOutput("midreset_remaining", exp_q.size(), 4);
    exp_q.delete();
    first_pending = 1'b0;
    d0 = done_count;
    repeat (5) @(negedge clk);
    checkOutput("midreset_no_done", done_count - d0, 0);
    applyStimulus(2, 1, 0, 3, 0, 7);
    waitDone(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
